mv_array_reader: RTL and testbench
==================================

Name: mv_array_reader

Overview:
- Read-side counterpart to the motion-estimation controller that fills the motion-vector array.
- The controller writes one MV per block at address {count_y, count_x}.
- This block reads the completed frame's MV array back in raster order after a frame ends.
- It streams each entry on a valid/ready interface with row and frame markers, for the downstream MV packer/encoder.

Parameters:
TOTALBLOCKX, 79, last block column index (columns 0..TOTALBLOCKX)
TOTALBLOCKY, 44, last block row index (rows 0..TOTALBLOCKY)
MV_W, 16, width of one stored MV entry
CNT_W, 7, width of each of the x and y counters; address width = 2*CNT_W

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: frame complete, begin readout
mv_rden  output  1  MV array read enable
mv_rdaddr  output  2*CNT_W  read address {y, x}; same packing as the writer's curpos
mv_rddata  input  MV_W  read data, valid the cycle after mv_rden
out_valid  output  1  stream beat valid
out_ready  input  1  downstream accept
out_data  output  MV_W  MV entry
out_rowlast  output  1  beat is column TOTALBLOCKX
out_framelast  output  1  beat is final entry (TOTALBLOCKX, TOTALBLOCKY)
busy  output  1  readout in progress
done  output  1  one-cycle pulse after final beat accepted

Behaviour:
- Reset (async): all outputs 0, FSM=IDLE, x=y=0, FIFO empty, in-flight flag cleared. Read data returning after reset is discarded.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 -> READ, x=y=0. busy=1 from the next cycle. start is ignored in every other state.
  - READ: issue reads in raster order (x increments; at x==TOTALBLOCKX, x->0 and y increments).
    - After issuing (TOTALBLOCKX, TOTALBLOCKY) -> DRAIN. No further mv_rden is asserted.
  - DRAIN: stay until the framelast beat handshakes (out_valid && out_ready), then -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then -> IDLE.
- mv_rdaddr = {y, x} when mv_rden=1; it holds its last value otherwise.
- Output buffer: 2-entry FIFO holding {data, rowlast, framelast}.
  - rowlast and framelast are computed from x/y at issue time and carried alongside the read in a 1-cycle pipeline register.
- Credit rule: mv_rden may be high in cycle t only if (FIFO occupancy + in-flight reads − pop in cycle t) < 2.
  - pop = out_valid && out_ready.
  - In-flight reads are at most 1 (1-cycle memory latency).
  - No data is ever dropped; the FIFO never overflows.
- Latency:
  - start sampled at edge k -> first mv_rden in the cycle after k.
  - Data written into the FIFO at the edge after the rden cycle -> out_valid visible 2 cycles after mv_rden.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Stream rules:
  - out_valid = FIFO non-empty; out_data/flags = FIFO head.
  - While out_valid && !out_ready, out_data, out_rowlast and out_framelast hold stable.
  - out_valid never drops without a handshake.
- Entry count per frame: (TOTALBLOCKX+1)*(TOTALBLOCKY+1) = 3600 at defaults.
  - out_rowlast asserts on 45 beats; out_framelast on exactly 1 beat, which also has out_rowlast=1.
- Simultaneous events:
  - Push and pop in the same cycle keep occupancy unchanged.
  - The rden decision may use that cycle's pop.
- Reset mid-frame aborts immediately. A later start restarts at address 0.

Test Plan:
- Default params, MV memory preloaded with data = address, out_ready=1, start pulse at cycle 10:
  - first mv_rden at cycle 11 with addr 0x0000; first out_valid at cycle 13;
  - 3600 beats in order; out_rowlast on beats 79, 159, …, 3599; out_framelast only on beat 3599 (addr {44,79});
  - done one cycle after the last handshake; busy low afterwards.
- out_ready held 0 for 100 cycles after start:
  - exactly 2 mv_rden pulses issued, then mv_rden stays 0;
  - out_data = entry 0 stable throughout;
  - on release, stream resumes with no gap-induced loss.
- Random out_ready (50% duty), full frame:
  - scoreboard sees all 3600 entries exactly once, in order;
  - FIFO occupancy + in-flight never exceeds 2;
  - held data is stable whenever stalled.
- start pulsed again at beat 500 during readout:
  - ignored; sequence continues uninterrupted;
  - single done pulse at end.
- reset asserted at beat 1000, released, then new start:
  - during reset all outputs are 0;
  - new stream begins at addr 0 with data 0;
  - the stale in-flight read never appears at the output.
- TOTALBLOCKX=2, TOTALBLOCKY=1, out_ready=1:
  - addresses {0,0},{0,1},{0,2},{1,0},{1,1},{1,2};
  - rowlast on beats 2 and 5; framelast on beat 5; done after 6 handshakes.

Source files
------------

// File: rtl/mv_array_reader.sv
// mv_array_reader: reads the completed MV array back in raster order and streams it
// over valid/ready with row/frame markers through a 2-entry credit-limited FIFO.
module mv_array_reader #(
    parameter int TOTALBLOCKX = 79,
    parameter int TOTALBLOCKY = 44,
    parameter int MV_W        = 16,
    parameter int CNT_W       = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               mv_rden,
    output logic [2*CNT_W-1:0] mv_rdaddr,
    input  logic [MV_W-1:0]    mv_rddata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MV_W-1:0]    out_data,
    output logic               out_rowlast,
    output logic               out_framelast,
    output logic               busy,
    output logic               done
);
    localparam int E_W = MV_W + 2;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
    logic [2*CNT_W-1:0] addr_q;
    logic               infl_q;
    logic [1:0]         infl_flags_q;
    logic [E_W-1:0]     fifo_q [2];
    logic               wp_q, rp_q;
    logic [1:0]         cnt_q;
    logic               last_x, last_y, pop, push;
    logic [2:0]         occ;
    logic [E_W-1:0]     head;

    assign last_x        = x_q == CNT_W'(TOTALBLOCKX);
    assign last_y        = y_q == CNT_W'(TOTALBLOCKY);
    assign head          = fifo_q[rp_q];
    assign out_valid     = cnt_q != 2'd0;
    assign out_data      = head[E_W-1:2];
    assign out_rowlast   = head[1];
    assign out_framelast = head[0];
    assign pop           = out_valid && out_ready;
    assign push          = infl_q;
    // Slots already claimed after this cycle's pop; a new read needs one free.
    assign occ           = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
    assign busy          = state_q == READ || state_q == DRAIN;
    assign done          = state_q == DONE;
    assign mv_rdaddr     = mv_rden ? {y_q, x_q} : addr_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        mv_rden = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            READ: begin
                mv_rden = occ < 3'd2;
                if (mv_rden) begin
                    x_d = last_x ? '0 : x_q + 1'b1;
                    y_d = (last_x && !last_y) ? y_q + 1'b1 : y_q;
                    state_d = (last_x && last_y) ? DRAIN : READ;
                end
            end
            DRAIN:   state_d = (pop && out_framelast) ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (mv_rden) addr_q <= {y_q, x_q};
        end
    end

    // Flags travel with the read so they land in the FIFO alongside its data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            infl_q       <= 1'b0;
            infl_flags_q <= 2'b00;
        end else begin
            infl_q       <= mv_rden;
            infl_flags_q <= {last_x, last_x && last_y};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (push) fifo_q[wp_q] <= {mv_rddata, infl_flags_q};
            wp_q  <= wp_q ^ push;
            rp_q  <= rp_q ^ pop;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_mv_array_reader.sv
// tb_mv_array_reader: randomized-ready frame readouts checked against a raster-order model.
module tb_mv_array_reader;
    localparam int TX = 79, TY = 44, N = (TX + 1) * (TY + 1);

    logic        clk = 0, reset = 1, start = 0, out_ready = 0;
    logic        mv_rden, out_valid, out_rowlast, out_framelast, busy, done;
    logic [13:0] mv_rdaddr;
    logic [15:0] mv_rddata, out_data;
    logic        start_b = 0, ready_b = 0;
    logic        rden_b, valid_b, rowlast_b, framelast_b, busy_b, done_b;
    logic [13:0] rdaddr_b;
    logic [15:0] rddata_b, data_b;
    logic [15:0] salt = 0;

    int checks = 0, errors = 0, tick = 0;
    int beat, issued, rd_cnt, row_cnt, fl_cnt, done_cnt, first_rd, first_vl, last_hs;
    int beat_b = 0, issued_b = 0, done_b_cnt = 0;

    mv_array_reader dut (
        .clk(clk), .reset(reset), .start(start), .mv_rden(mv_rden), .mv_rdaddr(mv_rdaddr),
        .mv_rddata(mv_rddata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rowlast(out_rowlast), .out_framelast(out_framelast), .busy(busy), .done(done)
    );

    mv_array_reader #(.TOTALBLOCKX(2), .TOTALBLOCKY(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mv_rden(rden_b), .mv_rdaddr(rdaddr_b),
        .mv_rddata(rddata_b), .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
        .out_rowlast(rowlast_b), .out_framelast(framelast_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Memory models: stored entry is its own address xor a per-frame salt.
    always @(posedge clk) mv_rddata <= mv_rden ? (16'(mv_rdaddr) ^ salt) : 16'($urandom);
    always @(posedge clk) rddata_b  <= rden_b ? 16'(rdaddr_b) : 16'($urandom);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] ea(input int i);
        return {7'(i / (TX + 1)), 7'(i % (TX + 1))};
    endfunction

    function automatic logic [13:0] eb(input int i);
        return {7'(i / 3), 7'(i % 3)};
    endfunction

    always @(negedge clk) begin
        tick++;
        if (reset) begin
            check("rst_ctl", 32'({mv_rden, out_valid, out_rowlast, out_framelast, busy, done}), 0);
            check("rst_bus", 32'({mv_rdaddr, out_data}), 0);
        end else begin
            if (mv_rden) begin
                check("rd_addr", 32'(mv_rdaddr), 32'(ea(issued)));
                if (issued == 0) first_rd = tick;
                issued++;
                rd_cnt++;
            end
            if (out_valid) begin
                check("data", 32'(out_data), 32'(16'(ea(beat)) ^ salt));
                check("flags", 32'({out_rowlast, out_framelast}), 32'({beat % (TX + 1) == TX, beat == N - 1}));
                if (first_vl < 0) first_vl = tick;
                if (out_ready) begin
                    row_cnt += int'(out_rowlast);
                    fl_cnt  += int'(out_framelast);
                    beat++;
                    last_hs = tick;
                end
            end
            check("credit", 32'((issued - beat) <= 2), 1);
            if (done) begin
                done_cnt++;
                check("done_lat", tick - last_hs, 1);
                check("done_beats", beat, N);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (rden_b) begin
                check("b_addr", 32'(rdaddr_b), 32'(eb(issued_b)));
                issued_b++;
            end
            if (valid_b && ready_b) begin
                check("b_data", 32'(data_b), 32'(eb(beat_b)));
                check("b_flags", 32'({rowlast_b, framelast_b}), 32'({beat_b % 3 == 2, beat_b == 5}));
                beat_b++;
            end
            if (done_b) begin
                done_b_cnt++;
                check("b_done_beats", beat_b, 6);
            end
        end
    end

    task automatic new_frame(input logic [15:0] s);
        salt = s; beat = 0; issued = 0; rd_cnt = 0; row_cnt = 0; fl_cnt = 0;
        done_cnt = 0; first_rd = -1; first_vl = -1; last_hs = -100;
    endtask

    task automatic kick(output int st);
        st = tick + 1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic run(input bit rnd, input int restart_at, input int abort_at, output bit aborted);
        bit sent = 0;
        int n = 0;
        aborted = 0;
        while (done_cnt == 0 && n < 30000) begin
            @(posedge clk); #1;
            n++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = 0;
            if (restart_at >= 0 && !sent && beat >= restart_at) begin
                start = 1;
                sent = 1;
            end
            if (abort_at >= 0 && beat >= abort_at) begin
                aborted = 1;
                return;
            end
        end
        check("no_timeout", 32'(done_cnt != 0), 1);
    endtask

    task automatic end_frame();
        repeat (5) begin @(posedge clk); #1; out_ready = 1; end
        check("end_busy", 32'(busy), 0);
        check("end_done_cnt", done_cnt, 1);
        check("end_beats", beat, N);
        check("end_issued", issued, N);
        check("end_rowlast", row_cnt, TY + 1);
        check("end_framelast", fl_cnt, 1);
    endtask

    initial begin
        bit ab;
        int st;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        new_frame(16'h0);
        out_ready = 1;
        ready_b = 1;
        repeat (9) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 0);
        start_b = 1;
        kick(st);
        start_b = 0;
        check("busy_rise", 32'(busy), 1);
        run(0, -1, -1, ab);
        check("rd_lat", first_rd - st, 1);
        check("vl_lat", first_vl - st, 3);
        end_frame();
        check("b_done_cnt", done_b_cnt, 1);
        check("b_beats", beat_b, 6);

        new_frame(16'($urandom));
        out_ready = 0;
        kick(st);
        repeat (100) begin @(posedge clk); #1; end
        check("stall_rd", rd_cnt, 2);
        check("stall_beats", beat, 0);
        check("stall_valid", 32'(out_valid), 1);
        run(0, -1, -1, ab);
        end_frame();

        new_frame(16'($urandom));
        kick(st);
        run(1, 500, -1, ab);
        end_frame();

        new_frame(16'($urandom));
        kick(st);
        run(1, -1, 1000, ab);
        reset = 1;
        check("abort_hit", 32'(ab), 1);
        repeat (3) begin @(posedge clk); #1; end
        reset = 0;
        new_frame(16'h0);
        kick(st);
        run(1, -1, -1, ab);
        end_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
